divr_seq: RTL and testbench

//  Parametrised sequential divider, successor to the radix-2 primitive. Divides a 2N-bit dividend
//  by an N-bit divisor giving N-bit quotient/remainder (x86 DIV/IDIV semantics), signed or unsigned.

---
 rtl/divr_seq.sv | 179 +++++++++++++++++
 tb/tb_divr_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divr_seq.sv
// Sequential 2N/N restoring divider with x86 DIV/IDIV semantics, UNROLL quotient bits per cycle,
// req/rdy/done handshake, abort, clock enable, divide-by-zero and quotient-overflow reporting.
module divr_seq #(
    parameter int N      = 32,
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           abort,
    input  logic           req,
    input  logic           su,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           rdy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           dz,
    output logic           ovf
);
    localparam int            STEPS   = N / UNROLL;
    localparam int            CW      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST    = CW'(STEPS - 1);
    localparam logic [N-1:0]  ONES    = {N{1'b1}};
    localparam logic [N-1:0]  POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  NEG_MAX = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, SGN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d, r_q, r_d;
    logic           dz_q, dz_d, ovf_q, ovf_d;
    logic           su_q, su_d, asg_q, asg_d, bsg_q, bsg_d;
    logic [N-1:0]   bmag_q, bmag_d, rem_q, rem_d, sh_q, sh_d;

    logic [2*N-1:0] amag;
    logic [N-1:0]   bmag_in;
    logic [N:0]     rem_t;
    logic [N-1:0]   sh_t;
    logic [N-1:0]   step_rem, step_sh;
    logic           qneg;

    // The most negative dividend negates to itself, which is its exact unsigned magnitude.
    assign amag    = (su && a[2*N-1]) ? ({(2*N){1'b0}} - a) : a;
    assign bmag_in = (su && b[N-1]) ? ({N{1'b0}} - b) : b;
    assign qneg    = asg_q ^ bsg_q;

    // UNROLL restoring steps; sh_t shifts dividend bits out and quotient bits in.
    always_comb begin
        rem_t = {1'b0, rem_q};
        sh_t  = sh_q;
        for (int i = 0; i < UNROLL; i++) begin
            rem_t = {rem_t[N-1:0], sh_t[N-1]};
            sh_t  = {sh_t[N-2:0], 1'b0};
            if (rem_t >= {1'b0, bmag_q}) begin
                rem_t   = rem_t - {1'b0, bmag_q};
                sh_t[0] = 1'b1;
            end
        end
        step_rem = rem_t[N-1:0];
        step_sh  = sh_t;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        su_d    = su_q;
        asg_d   = asg_q;
        bsg_d   = bsg_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (!abort && req) begin
                    su_d   = su;
                    asg_d  = su & a[2*N-1];
                    bsg_d  = su & b[N-1];
                    bmag_d = bmag_in;
                    cnt_d  = '0;
                    if (b == {N{1'b0}}) begin
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        q_d     = ONES;
                        r_d     = {N{1'b0}};
                        state_d = DONE;
                    end else if (amag[2*N-1:N] >= bmag_in) begin
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                        q_d     = ONES;
                        r_d     = {N{1'b0}};
                        state_d = DONE;
                    end else begin
                        rem_d   = amag[2*N-1:N];
                        sh_d    = amag[N-1:0];
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    sh_d  = step_sh;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = SGN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SGN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    dz_d    = 1'b0;
                    if (su_q && ((!qneg && sh_q > POS_MAX) || (qneg && sh_q > NEG_MAX))) begin
                        ovf_d = 1'b1;
                        q_d   = ONES;
                        r_d   = {N{1'b0}};
                    end else begin
                        ovf_d = 1'b0;
                        q_d   = qneg  ? ({N{1'b0}} - sh_q)  : sh_q;
                        r_d   = asg_q ? ({N{1'b0}} - rem_q) : rem_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand/working registers are always written before they are read, so no reset.
    always_ff @(posedge clk) begin
        if (ce) begin
            su_q   <= su_d;
            asg_q  <= asg_d;
            bsg_q  <= bsg_d;
            bmag_q <= bmag_d;
            rem_q  <= rem_d;
            sh_q   <= sh_d;
        end
    end

    assign rdy  = (state_q == IDLE) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_divr_seq.sv
// Directed bench for divr_seq: three instances (N=32/U=1, N=32/U=4, N=16/U=1), hand-computed
// vectors, latency, abort, ce stalls, async reset, plus a random sweep against a wide-integer model.
module tb_divr_seq;
    logic        clk = 1'b0;
    logic        rst_n, ce, abort, su;
    logic        req0, req1, req2;
    logic [63:0] a;
    logic [31:0] b;
    logic [2:0]  rdy_v, done_v, dz_v, ovf_v;
    logic [31:0] q0, r0, q1, r1;
    logic [15:0] q16, r16;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    int lat;
    int n;

    always #5 clk = ~clk;

    divr_seq #(.N(32), .UNROLL(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .abort(abort), .req(req0), .su(su), .a(a), .b(b),
        .rdy(rdy_v[0]), .done(done_v[0]), .q(q0), .r(r0), .dz(dz_v[0]), .ovf(ovf_v[0]));
    divr_seq #(.N(32), .UNROLL(4)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .abort(abort), .req(req1), .su(su), .a(a), .b(b),
        .rdy(rdy_v[1]), .done(done_v[1]), .q(q1), .r(r1), .dz(dz_v[1]), .ovf(ovf_v[1]));
    divr_seq #(.N(16), .UNROLL(1)) u2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .abort(abort), .req(req2), .su(su),
        .a(a[31:0]), .b(b[15:0]),
        .rdy(rdy_v[2]), .done(done_v[2]), .q(q16), .r(r16), .dz(dz_v[2]), .ovf(ovf_v[2]));

    function automatic logic [65:0] res(input int d);
        case (d)
            0:       return {dz_v[0], ovf_v[0], q0, r0};
            1:       return {dz_v[1], ovf_v[1], q1, r1};
            default: return {dz_v[2], ovf_v[2], 16'h0, q16, 16'h0, r16};
        endcase
    endfunction

    // Reference: exact wide signed/unsigned division, then range check on the quotient.
    function automatic logic [65:0] model(input int nb, input logic s, input logic [63:0] av,
                                          input logic [31:0] bv);
        logic signed [127:0] sa, sb, qq, rr, one, hi, lo;
        logic [31:0] m;
        int sha, shb;
        sha = 128 - 2 * nb;
        shb = 128 - nb;
        one = 128'sd1;
        m   = (nb == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        if (bv == 32'h0) return {2'b10, m, 32'h0};
        if (s) begin
            sa = $signed({64'h0, av} << sha) >>> sha;
            sb = $signed({96'h0, bv} << shb) >>> shb;
            hi = (one <<< (nb - 1)) - one;
            lo = -(one <<< (nb - 1));
        end else begin
            sa = $signed({64'h0, av});
            sb = $signed({96'h0, bv});
            hi = (one <<< nb) - one;
            lo = 128'sd0;
        end
        qq = sa / sb;
        rr = sa % sb;
        if (qq > hi || qq < lo) return {2'b01, m, 32'h0};
        return {2'b00, qq[31:0] & m, rr[31:0] & m};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input logic v);
        case (d)
            0:       req0 = v;
            1:       req1 = v;
            default: req2 = v;
        endcase
    endtask

    task automatic accept(input int d, input logic s, input logic [63:0] av, input logic [31:0] bv);
        su    = s;
        a     = av;
        b     = bv;
        ce    = 1'b1;
        abort = 1'b0;
        set_req(d, 1'b1);
        @(posedge clk);
        #1;
        set_req(d, 1'b0);
    endtask

    // Latency counts the accept edge plus every enabled edge until done is seen.
    task automatic wait_done(input int d, input bit tog, output int l);
        int guard;
        bit c;
        guard = 0;
        l     = 1;
        while (done_v[d] !== 1'b1 && guard < 400) begin
            c  = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            ce = c;
            @(posedge clk);
            #1;
            if (c) l++;
            guard++;
        end
        ce = 1'b1;
        if (guard >= 400) chk("timeout", 66'(done_v[d]), 66'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ce = 1'b1; abort = 1'b0; su = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", res(0), 66'h0);
        chk("rst_rdy_done", 66'({rdy_v, done_v}), 66'({3'b111, 3'b000}));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        accept(0, 1'b0, 64'd100, 32'd7);
        wait_done(0, 1'b0, lat);
        chk("u100_7", res(0), {2'b00, 32'd14, 32'd2});
        chk("u100_7_lat", 66'(lat), 66'd34);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 66'({rdy_v[0], done_v[0]}), 66'(2'b10));

        accept(0, 1'b1, -64'sd1283, -32'sd14);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_rdy", 66'(rdy_v[0]), 66'd0);
        su = 1'b0; a = 64'd100; b = 32'd7; req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_done(0, 1'b0, lat);
        chk("s_n1283_n14", res(0), {2'b00, 32'h0000_005B, 32'hFFFF_FFF7});

        accept(0, 1'b1, 64'd1283, -32'sd14);
        wait_done(0, 1'b0, lat);
        chk("s_1283_n14", res(0), {2'b00, 32'hFFFF_FFA5, 32'd9});
        chk("b2b_lat", 66'(lat), 66'd34);

        accept(0, 1'b0, 64'd12345, 32'd0);
        wait_done(0, 1'b0, lat);
        chk("dz", res(0), {2'b10, 32'hFFFF_FFFF, 32'h0});
        chk("dz_lat", 66'(lat), 66'd1);

        accept(0, 1'b0, 64'h1_0000_0000, 32'd1);
        wait_done(0, 1'b0, lat);
        chk("early_ovf", res(0), {2'b01, 32'hFFFF_FFFF, 32'h0});
        chk("early_ovf_lat", 66'(lat), 66'd1);

        accept(0, 1'b1, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 1'b0, lat);
        chk("sgn_ovf", res(0), {2'b01, 32'hFFFF_FFFF, 32'h0});
        chk("sgn_ovf_lat", 66'(lat), 66'd34);

        accept(0, 1'b1, 64'hFFFF_FFFF_8000_0000, 32'd1);
        wait_done(0, 1'b0, lat);
        chk("min_div_1", res(0), {2'b00, 32'h8000_0000, 32'h0});
        @(posedge clk);
        #1;

        accept(0, 1'b0, 64'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_rdy", 66'({rdy_v[0], done_v[0]}), 66'(2'b10));
        chk("abort_hold", res(0), {2'b00, 32'h8000_0000, 32'h0});
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_v[0]) n++;
        end
        chk("abort_no_done", 66'(n), 66'd0);

        su = 1'b0; a = 64'd5; b = 32'd0; req0 = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0; abort = 1'b0;
        chk("abort_blocks_req", 66'({rdy_v[0], done_v[0], dz_v[0]}), 66'(3'b100));

        accept(0, 1'b0, 64'd100, 32'd7);
        wait_done(0, 1'b0, lat);
        chk("after_abort", res(0), {2'b00, 32'd14, 32'd2});
        @(posedge clk);
        #1;

        accept(0, 1'b0, 64'd1000000, 32'd37);
        wait_done(0, 1'b1, lat);
        chk("ce_toggle", res(0), {2'b00, 32'd27027, 32'd1});
        chk("ce_toggle_lat", 66'(lat), 66'd34);
        ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_done_held", 66'(done_v[0]), 66'd1);
        ce = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", 66'(done_v[0]), 66'd0);

        accept(0, 1'b0, 64'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_res", res(0), 66'h0);
        chk("async_rst_rdy", 66'({rdy_v[0], done_v[0]}), 66'(2'b10));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        accept(1, 1'b0, 64'd100, 32'd7);
        wait_done(1, 1'b0, lat);
        chk("u4_100_7", res(1), {2'b00, 32'd14, 32'd2});
        chk("u4_lat", 66'(lat), 66'd10);

        accept(2, 1'b1, 64'h0000_0000_FFFF_FAFD, 32'h0000_FFF2);
        wait_done(2, 1'b0, lat);
        chk("n16_s", res(2), {2'b00, 32'h0000_005B, 32'h0000_FFF7});
        chk("n16_lat", 66'(lat), 66'd18);

        for (int i = 0; i < 24; i++) begin
            int          d, nb;
            logic        s;
            logic [63:0] av;
            logic [31:0] bv;
            d  = (i % 2 == 1) ? 1 : 2;
            nb = (d == 1) ? 32 : 16;
            s  = 1'($urandom_range(0, 1));
            av = {$urandom, $urandom} >> $urandom_range(0, 63);
            bv = $urandom >> $urandom_range(0, 31);
            if (nb == 16) begin
                av = av & 64'h0000_0000_FFFF_FFFF;
                bv = bv & 32'h0000_FFFF;
            end
            accept(d, s, av, bv);
            wait_done(d, (i % 3 == 0), lat);
            chk($sformatf("sweep%0d_n%0d_s%0d_a%h_b%h", i, nb, s, av, bv), res(d), model(nb, s, av, bv));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
